// File: rtl/load_store_unit.sv
// Data-side load/store unit: RV load/store sizes on a byte-lane RAM with
// optional wait states, a valid/ready request handshake and error codes.
module load_store_unit #(
  parameter int XLEN        = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic [1:0]      rsp_err
);
  localparam int LANES = XLEN / 8;
  localparam int LB    = $clog2(LANES);
  localparam int AW    = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t          r_state, w_next;
  logic [3:0]      r_cnt;
  logic            r_we;
  logic [2:0]      r_funct3;
  logic [XLEN-1:0] r_addr, r_wdata;
  logic [1:0]      r_err;
  logic [XLEN-1:0] r_rdata;
  logic [XLEN-1:0] r_mem [DEPTH];

  logic            w_accept, w_legal, w_enter_resp, w_commit;
  logic            w_use_we;
  logic [2:0]      w_use_funct3;
  logic [XLEN-1:0] w_use_addr, w_use_wdata, w_wword;
  logic [1:0]      w_class;
  logic [LB-1:0]   w_lane;
  logic [AW-1:0]   w_idx;
  logic [7:0]      w_mask;
  logic [LANES-1:0] w_be;

  function automatic logic [1:0] classify(input logic we, input logic [2:0] f,
                                          input logic [XLEN-1:0] a);
    logic illegal, misal, oor;
    if (we) illegal = f[2] || (f[1:0] == 2'b11 && XLEN == 32);
    else    illegal = (f == 3'b111) || (XLEN == 32 && (f == 3'b011 || f == 3'b110));
    case (f[1:0])
      2'b01:   misal = a[0];
      2'b10:   misal = (a[1:0] != 2'b00);
      2'b11:   misal = (a[2:0] != 3'b000);
      default: misal = 1'b0;
    endcase
    oor = (a >> LB) >= XLEN'(DEPTH);
    if (illegal)    classify = 2'b10;
    else if (misal) classify = 2'b01;
    else if (oor)   classify = 2'b11;
    else            classify = 2'b00;
  endfunction

  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] w, input logic [2:0] f);
    case (f[1:0])
      2'b00: begin
        if (f[2]) extend = XLEN'(w[7:0]);
        else      extend = XLEN'($signed(w[7:0]));
      end
      2'b01: begin
        if (f[2]) extend = XLEN'(w[15:0]);
        else      extend = XLEN'($signed(w[15:0]));
      end
      2'b10: begin
        if (f[2]) extend = XLEN'(w[31:0]);
        else      extend = XLEN'($signed(w[31:0]));
      end
      default: extend = w;
    endcase
  endfunction

  assign req_ready = (r_state != S_WAIT);
  assign w_accept  = req_valid && req_ready;

  // While waiting, the latched request drives the RAM; otherwise the live inputs do.
  assign w_use_we     = (r_state == S_WAIT) ? r_we     : req_we;
  assign w_use_funct3 = (r_state == S_WAIT) ? r_funct3 : req_funct3;
  assign w_use_addr   = (r_state == S_WAIT) ? r_addr   : req_addr;
  assign w_use_wdata  = (r_state == S_WAIT) ? r_wdata  : req_wdata;

  assign w_class = classify(w_use_we, w_use_funct3, w_use_addr);
  assign w_legal = (w_class == 2'b00);
  assign w_lane  = w_use_addr[LB-1:0];
  assign w_idx   = w_use_addr[AW+LB-1:LB];
  assign w_wword = w_use_wdata << {w_lane, 3'b000};

  always_comb begin
    case (w_use_funct3[1:0])
      2'b00:   w_mask = 8'h01;
      2'b01:   w_mask = 8'h03;
      2'b10:   w_mask = 8'h0F;
      default: w_mask = 8'hFF;
    endcase
    w_be = LANES'(w_mask) << w_lane;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_RESP: begin
        if (w_accept) w_next = (!w_legal || WAIT_STATES == 0) ? S_RESP : S_WAIT;
        else          w_next = S_IDLE;
      end
      S_WAIT:  if (r_cnt == 4'd0) w_next = S_RESP;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_enter_resp = reset && (w_next == S_RESP);
  assign w_commit     = w_enter_resp && w_use_we && w_legal;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next;
      if (w_accept && w_legal && WAIT_STATES > 0) r_cnt <= 4'(WAIT_STATES - 1);
      else if (r_state == S_WAIT && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we     <= req_we;
      r_funct3 <= req_funct3;
      r_addr   <= req_addr;
      r_wdata  <= req_wdata;
      r_err    <= w_class;
    end
    if (w_enter_resp) begin
      if (!w_use_we && w_legal)
        r_rdata <= extend(r_mem[w_idx] >> {w_lane, 3'b000}, w_use_funct3);
      else
        r_rdata <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int i = 0; i < LANES; i++)
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wword[8*i +: 8];
    end
  end

  assign rsp_valid = (r_state == S_RESP);
  assign rsp_rdata = rsp_valid ? r_rdata : '0;
  assign rsp_err   = rsp_valid ? r_err : 2'b00;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a 2-wait-state unit and a 0-wait-state unit,
// both compared against a byte-array reference model.
module tb_load_store_unit;
  localparam int WS = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid2, valid0;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        ready2, rv2, ready0, rv0;
  logic [31:0] rd2, rd0;
  logic [1:0]  err2, err0;

  logic [7:0]  mem2 [1024];
  logic [7:0]  mem0 [1024];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  load_store_unit #(.XLEN(32), .DEPTH(256), .WAIT_STATES(WS)) u_dut2 (
    .clk(clk), .reset(rst_n), .req_valid(valid2), .req_ready(ready2),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv2), .rsp_rdata(rd2), .rsp_err(err2));

  load_store_unit #(.XLEN(32), .DEPTH(256), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset(rst_n), .req_valid(valid0), .req_ready(ready0),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_err(err0));

  // Reference: memory is a flat byte array, sizes are 1<<funct3[1:0] bytes.
  function automatic void model(input bit sel, input bit we, input logic [2:0] f,
                                input logic [31:0] a, input logic [31:0] wd,
                                output logic [1:0] err, output logic [31:0] rd);
    int sz;
    logic [31:0] v;
    sz = 1 << f[1:0];
    rd = 32'd0;
    if (we ? (f > 3'd2) : (f == 3'd3 || f == 3'd6 || f == 3'd7)) err = 2'd2;
    else if (a % sz != 0)  err = 2'd1;
    else if (a / 4 >= 256) err = 2'd3;
    else begin
      err = 2'd0;
      if (we) begin
        for (int k = 0; k < sz; k++) begin
          if (sel) mem0[int'(a) + k] = wd[8*k +: 8];
          else     mem2[int'(a) + k] = wd[8*k +: 8];
        end
      end else begin
        v = 32'd0;
        for (int k = 0; k < sz; k++)
          v = v | (32'(sel ? mem0[int'(a) + k] : mem2[int'(a) + k]) << (8*k));
        if (!f[2] && sz < 4 && v[8*sz-1]) v = v | (~32'd0 << (8*sz));
        rd = v;
      end
    end
  endfunction

  task automatic xact(input bit sel, input bit we, input logic [2:0] f,
                      input logic [31:0] a, input logic [31:0] wd,
                      output int lat, output logic [1:0] err, output logic [31:0] rd);
    @(negedge clk);
    req_we = we; req_funct3 = f; req_addr = a; req_wdata = wd;
    if (sel) valid0 = 1'b1; else valid2 = 1'b1;
    @(negedge clk);
    valid0 = 1'b0; valid2 = 1'b0;
    lat = 1;
    while (!(sel ? rv0 : rv2) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    err = sel ? err0 : err2;
    rd  = sel ? rd0 : rd2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid2 = 1'b0; valid0 = 1'b0;
    req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    repeat (3) @(negedge clk);
    total++;
    if ({rv2, err2, rd2} !== 35'd0) begin
      bad++; $display("FAIL reset_out2: got v=%b e=%b d=%h want all 0", rv2, err2, rd2);
    end
    total++;
    if ({rv0, err0, rd0} !== 35'd0) begin
      bad++; $display("FAIL reset_out0: got v=%b e=%b d=%h want all 0", rv0, err0, rd0);
    end
    total++;
    if ({ready2, ready0} !== 2'b11) begin
      bad++; $display("FAIL reset_ready: got %b%b want 11", ready2, ready0);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_prefill();
    int lat; logic [1:0] e, ee; logic [31:0] r, er, d;
    for (int w = 0; w < 64; w++) begin
      d = $urandom;
      for (int s = 0; s < 2; s++) begin
        xact(s[0], 1'b1, 3'b010, 32'(4*w), d, lat, e, r);
        model(s[0], 1'b1, 3'b010, 32'(4*w), d, ee, er);
        total++;
        if (e !== 2'd0 || r !== 32'd0) begin
          bad++; $display("FAIL prefill[%0d/%0d]: got e=%b d=%h want 0", s, w, e, r);
        end
      end
    end
  endtask

  task automatic test_wait_latency();
    int lat; logic [1:0] e, ee; logic [31:0] r, er;
    xact(1'b0, 1'b1, 3'b010, 32'h64, 32'd25, lat, e, r);
    model(1'b0, 1'b1, 3'b010, 32'h64, 32'd25, ee, er);
    total++;
    if (lat != WS + 1 || e !== 2'b00) begin
      bad++; $display("FAIL sw_latency: got lat=%0d e=%b want lat=%0d e=00", lat, e, WS + 1);
    end
    xact(1'b0, 1'b0, 3'b010, 32'h64, 32'd0, lat, e, r);
    model(1'b0, 1'b0, 3'b010, 32'h64, 32'd0, ee, er);
    total++;
    if (lat != WS + 1 || r !== 32'h00000019) begin
      bad++; $display("FAIL lw_after_sw: got lat=%0d d=%h want lat=%0d d=00000019", lat, r, WS + 1);
    end
  endtask

  task automatic test_byte_merge();
    int lat; logic [1:0] e, ee; logic [31:0] r, er;
    logic [2:0]  f  [3] = '{3'b010, 3'b000, 3'b100};
    logic [31:0] ad [3] = '{32'h80, 32'h81, 32'h81};
    logic [31:0] ex [3] = '{32'h1122AB44, 32'hFFFFFFAB, 32'h000000AB};
    xact(1'b0, 1'b1, 3'b010, 32'h80, 32'h11223344, lat, e, r);
    model(1'b0, 1'b1, 3'b010, 32'h80, 32'h11223344, ee, er);
    xact(1'b0, 1'b1, 3'b000, 32'h81, 32'h000000AB, lat, e, r);
    model(1'b0, 1'b1, 3'b000, 32'h81, 32'h000000AB, ee, er);
    for (int i = 0; i < 3; i++) begin
      xact(1'b0, 1'b0, f[i], ad[i], 32'd0, lat, e, r);
      total++;
      if (r !== ex[i] || e !== 2'b00) begin
        bad++; $display("FAIL byte_merge[%0d]: got d=%h e=%b want d=%h e=00", i, r, e, ex[i]);
      end
    end
  endtask

  task automatic test_half();
    int lat; logic [1:0] e, ee; logic [31:0] r, er;
    xact(1'b0, 1'b1, 3'b001, 32'h86, 32'h00008001, lat, e, r);
    model(1'b0, 1'b1, 3'b001, 32'h86, 32'h00008001, ee, er);
    xact(1'b0, 1'b0, 3'b001, 32'h86, 32'd0, lat, e, r);
    total++;
    if (r !== 32'hFFFF8001) begin
      bad++; $display("FAIL lh: got %h want FFFF8001", r);
    end
    xact(1'b0, 1'b0, 3'b101, 32'h86, 32'd0, lat, e, r);
    total++;
    if (r !== 32'h00008001) begin
      bad++; $display("FAIL lhu: got %h want 00008001", r);
    end
    xact(1'b0, 1'b1, 3'b001, 32'h85, 32'h0000FFFF, lat, e, r);
    model(1'b0, 1'b1, 3'b001, 32'h85, 32'h0000FFFF, ee, er);
    total++;
    if (e !== 2'b01 || lat != 1) begin
      bad++; $display("FAIL sh_misaligned: got e=%b lat=%0d want e=01 lat=1", e, lat);
    end
    xact(1'b0, 1'b0, 3'b010, 32'h84, 32'd0, lat, e, r);
    model(1'b0, 1'b0, 3'b010, 32'h84, 32'd0, ee, er);
    total++;
    if (r !== er || r[31:16] !== 16'h8001) begin
      bad++; $display("FAIL word84_unchanged: got %h want %h", r, er);
    end
  endtask

  task automatic test_errors();
    int lat; logic [1:0] e, ee; logic [31:0] r, er;
    bit          we [10] = '{0, 0, 0, 1, 1, 0, 1, 0, 0, 1};
    logic [2:0]  f  [10] = '{3'b011, 3'b110, 3'b111, 3'b100, 3'b011,
                             3'b010, 3'b010, 3'b010, 3'b001, 3'b001};
    logic [31:0] ad [10] = '{32'h40, 32'h40, 32'h41, 32'h40, 32'h40,
                             32'h400, 32'h400, 32'h402, 32'h401, 32'h85};
    logic [1:0]  ex [10] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10,
                             2'b11, 2'b11, 2'b01, 2'b01, 2'b01};
    for (int i = 0; i < 10; i++) begin
      xact(1'b0, we[i], f[i], ad[i], 32'hCAFEF00D, lat, e, r);
      model(1'b0, we[i], f[i], ad[i], 32'hCAFEF00D, ee, er);
      total++;
      if (e !== ex[i] || r !== 32'd0 || lat != 1) begin
        bad++; $display("FAIL err[%0d]: got e=%b d=%h lat=%0d want e=%b d=0 lat=1",
                        i, e, r, lat, ex[i]);
      end
    end
    xact(1'b0, 1'b0, 3'b010, 32'h0, 32'd0, lat, e, r);
    model(1'b0, 1'b0, 3'b010, 32'h0, 32'd0, ee, er);
    total++;
    if (r !== er) begin
      bad++; $display("FAIL oor_no_write: word0 got %h want %h", r, er);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] ee; logic [31:0] er, a, wd; bit we;
    logic [31:0] d [4];
    for (int i = 0; i < 4; i++) d[i] = $urandom;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      we = (i < 4);
      a  = 32'h20 + 32'(4 * (i % 4));
      wd = we ? d[i] : 32'd0;
      req_we = we; req_funct3 = 3'b010; req_addr = a; req_wdata = wd; valid0 = 1'b1;
      model(1'b1, we, 3'b010, a, wd, ee, er);
      @(negedge clk);
      total++;
      if (rv0 !== 1'b1 || ready0 !== 1'b1 || err0 !== ee || rd0 !== er) begin
        bad++; $display("FAIL b2b[%0d]: got v=%b rdy=%b e=%b d=%h want v=1 rdy=1 e=%b d=%h",
                        i, rv0, ready0, err0, rd0, ee, er);
      end
    end
    valid0 = 1'b0;
  endtask

  task automatic test_random();
    int lat, elat; logic [1:0] e, ee; logic [31:0] r, er, a, wd;
    logic [2:0] f; bit we, sel;
    for (int i = 0; i < 80; i++) begin
      sel = bit'($urandom_range(0, 1));
      we  = bit'($urandom_range(0, 1));
      f   = 3'($urandom_range(0, 7));
      a   = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << f[1:0]) - 32'd1);
      if ($urandom_range(0, 7) == 0) a = a + 32'h400;
      wd  = $urandom;
      xact(sel, we, f, a, wd, lat, e, r);
      model(sel, we, f, a, wd, ee, er);
      elat = (sel || ee != 2'd0) ? 1 : WS + 1;
      total++;
      if (e !== ee || r !== er || lat != elat) begin
        bad++; $display("FAIL rand[%0d] s=%0d we=%0d f=%0d a=%h: got e=%b d=%h lat=%0d want e=%b d=%h lat=%0d",
                        i, sel, we, f, a, e, r, lat, ee, er, elat);
      end
    end
  endtask

  task automatic test_reset_wait();
    int lat; logic [1:0] e, ee; logic [31:0] r, er;
    @(negedge clk);
    req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = 32'hDEADBEEF;
    valid2 = 1'b1;
    @(negedge clk);
    valid2 = 1'b0;
    total++;
    if (ready2 !== 1'b0) begin
      bad++; $display("FAIL ready_in_wait: got %b want 0", ready2);
    end
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 1) begin
        rst_n = 1'b1;
        total++;
        if (ready2 !== 1'b1) begin
          bad++; $display("FAIL ready_after_reset: got %b want 1", ready2);
        end
      end
      total++;
      if (rv2 !== 1'b0) begin
        bad++; $display("FAIL no_rsp_after_reset[%0d]: got rsp_valid=%b want 0", i, rv2);
      end
    end
    xact(1'b0, 1'b0, 3'b010, 32'h10, 32'd0, lat, e, r);
    model(1'b0, 1'b0, 3'b010, 32'h10, 32'd0, ee, er);
    total++;
    if (r !== er || e !== 2'b00) begin
      bad++; $display("FAIL store_dropped: word10 got %h e=%b want %h e=00", r, e, er);
    end
  endtask

  initial begin
    test_reset();
    test_prefill();
    test_wait_latency();
    test_byte_merge();
    test_half();
    test_errors();
    test_back_to_back();
    test_random();
    test_reset_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
